// File: rtl/multicycle_main_control_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path: opcodes,
// controller states, ALU / mux select codes and the control-word bundle.
// The ALU control unit and the datapath muxes import the same package.
package multicycle_main_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // INIT must stay at zero so a freshly reset controller reads back 0.
  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_I_EXEC    = 4'd11,
    S_I_WB      = 4'd12,
    S_HALT      = 4'd13
  } state_e;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iOrD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       aluFunctSel;
    logic [1:0] pcSource;
    logic       instrDone;
    logic       illegalOp;
  } ctrl_t;

endpackage

// File: rtl/multicycle_main_control_decode.sv
// Combinational heart of the main controller: maps the current state, the
// IR opcode and the memory ready flag to the control word and next state.
// Build option: ILLEGAL_OP_TRAP_EN sends illegal opcodes to a HALT state.
module main_control_decode
  import multicycle_main_control_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] i_state,
  input  logic [5:0]         i_opcode,
  input  logic               i_mem_ready,
  output ctrl_t              o_ctrl,
  output logic [STATE_W-1:0] o_next_state
);

  localparam logic [STATE_W-1:0] L_INIT      = STATE_W'(S_INIT);
  localparam logic [STATE_W-1:0] L_FETCH     = STATE_W'(S_FETCH);
  localparam logic [STATE_W-1:0] L_DECODE    = STATE_W'(S_DECODE);
  localparam logic [STATE_W-1:0] L_MEM_ADDR  = STATE_W'(S_MEM_ADDR);
  localparam logic [STATE_W-1:0] L_MEM_READ  = STATE_W'(S_MEM_READ);
  localparam logic [STATE_W-1:0] L_MEM_WB    = STATE_W'(S_MEM_WB);
  localparam logic [STATE_W-1:0] L_MEM_WRITE = STATE_W'(S_MEM_WRITE);
  localparam logic [STATE_W-1:0] L_R_EXEC    = STATE_W'(S_R_EXEC);
  localparam logic [STATE_W-1:0] L_R_WB      = STATE_W'(S_R_WB);
  localparam logic [STATE_W-1:0] L_BRANCH    = STATE_W'(S_BRANCH);
  localparam logic [STATE_W-1:0] L_JUMP      = STATE_W'(S_JUMP);
  localparam logic [STATE_W-1:0] L_I_EXEC    = STATE_W'(S_I_EXEC);
  localparam logic [STATE_W-1:0] L_I_WB      = STATE_W'(S_I_WB);
`ifdef ILLEGAL_OP_TRAP_EN
  localparam logic [STATE_W-1:0] L_HALT      = STATE_W'(S_HALT);
`endif

  // Sequencing: memory states wait on ready, decode dispatches by opcode,
  // and anything not recognised as a live state recovers through INIT.
  always_comb begin
    o_next_state = L_INIT;
    case (i_state)
      L_INIT:      o_next_state = L_FETCH;
      L_FETCH:     o_next_state = i_mem_ready ? L_DECODE : L_FETCH;
      L_DECODE: begin
        case (i_opcode)
          OP_LW, OP_SW:              o_next_state = L_MEM_ADDR;
          OP_RTYPE:                  o_next_state = L_R_EXEC;
          OP_BEQ:                    o_next_state = L_BRANCH;
          OP_J:                      o_next_state = L_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI:  o_next_state = L_I_EXEC;
`ifdef ILLEGAL_OP_TRAP_EN
          default:                   o_next_state = L_HALT;
`else
          default:                   o_next_state = L_FETCH;
`endif
        endcase
      end
      L_MEM_ADDR:  o_next_state = (i_opcode == OP_LW) ? L_MEM_READ : L_MEM_WRITE;
      L_MEM_READ:  o_next_state = i_mem_ready ? L_MEM_WB : L_MEM_READ;
      L_MEM_WB:    o_next_state = L_FETCH;
      L_MEM_WRITE: o_next_state = i_mem_ready ? L_FETCH : L_MEM_WRITE;
      L_R_EXEC:    o_next_state = L_R_WB;
      L_R_WB:      o_next_state = L_FETCH;
      L_BRANCH:    o_next_state = L_FETCH;
      L_JUMP:      o_next_state = L_FETCH;
      L_I_EXEC:    o_next_state = L_I_WB;
      L_I_WB:      o_next_state = L_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
      L_HALT:      o_next_state = L_HALT;
`endif
      default:     o_next_state = L_INIT;
    endcase
  end

  // Control word: Moore decode of the state, with ready gating the fetch
  // loads and the store completion pulse; unlisted fields stay zero.
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      L_FETCH: begin
        o_ctrl.memRead  = 1'b1;
        o_ctrl.aluSrcB  = SRCB_FOUR;
        o_ctrl.aluOp    = ALUOP_ADD;
        o_ctrl.pcSource = PCSRC_ALU;
        o_ctrl.irWrite  = i_mem_ready;
        o_ctrl.pcWrite  = i_mem_ready;
      end
      L_DECODE: begin
        o_ctrl.aluSrcB = SRCB_IMM_SH;
        o_ctrl.aluOp   = ALUOP_ADD;
        case (i_opcode)
          OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
          OP_ADDI, OP_ANDI, OP_ORI: o_ctrl.illegalOp = 1'b0;
          default:                  o_ctrl.illegalOp = 1'b1;
        endcase
      end
      L_MEM_ADDR: begin
        o_ctrl.aluSrcA = 1'b1;
        o_ctrl.aluSrcB = SRCB_IMM;
        o_ctrl.aluOp   = ALUOP_ADD;
      end
      L_MEM_READ: begin
        o_ctrl.memRead = 1'b1;
        o_ctrl.iOrD    = 1'b1;
      end
      L_MEM_WB: begin
        o_ctrl.memToReg  = 1'b1;
        o_ctrl.regWrite  = 1'b1;
        o_ctrl.instrDone = 1'b1;
      end
      L_MEM_WRITE: begin
        o_ctrl.memWrite  = 1'b1;
        o_ctrl.iOrD      = 1'b1;
        o_ctrl.instrDone = i_mem_ready;
      end
      L_R_EXEC: begin
        o_ctrl.aluSrcA = 1'b1;
        o_ctrl.aluSrcB = SRCB_B;
        o_ctrl.aluOp   = ALUOP_FUNCT;
      end
      L_R_WB: begin
        o_ctrl.regDst    = 1'b1;
        o_ctrl.regWrite  = 1'b1;
        o_ctrl.instrDone = 1'b1;
      end
      L_BRANCH: begin
        o_ctrl.aluSrcA     = 1'b1;
        o_ctrl.aluOp       = ALUOP_SUB;
        o_ctrl.pcWriteCond = 1'b1;
        o_ctrl.pcSource    = PCSRC_ALUOUT;
        o_ctrl.instrDone   = 1'b1;
      end
      L_JUMP: begin
        o_ctrl.pcWrite   = 1'b1;
        o_ctrl.pcSource  = PCSRC_JUMP;
        o_ctrl.instrDone = 1'b1;
      end
      L_I_EXEC: begin
        o_ctrl.aluSrcA = 1'b1;
        o_ctrl.aluSrcB = SRCB_IMM;
        if (i_opcode == OP_ADDI) begin
          o_ctrl.aluOp       = ALUOP_ADD;
          o_ctrl.aluFunctSel = 1'b0;
        end else begin
          o_ctrl.aluOp       = ALUOP_IMM;
          o_ctrl.aluFunctSel = 1'b1;
        end
      end
      L_I_WB: begin
        o_ctrl.regDst    = 1'b0;
        o_ctrl.regWrite  = 1'b1;
        o_ctrl.instrDone = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM wrapper for the multi-cycle MIPS-subset datapath. Owns
// the state register and fans the decoded control word out to the ports.
// Build option: ILLEGAL_OP_TRAP_EN adds a HALT trap and the 'halted' port.
module multicycle_main_control
  import multicycle_main_control_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               alu_funct_sel,
  output logic [1:0]         pc_source,
  output logic               instr_done,
  output logic               illegal_op,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic               halted,
`endif
  output logic [STATE_W-1:0] state_dbg
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_nextState;
  ctrl_t              w_ctrl;

  main_control_decode #(.STATE_W(STATE_W)) u_decode (
    .i_state      (r_state),
    .i_opcode     (opcode),
    .i_mem_ready  (mem_ready),
    .o_ctrl       (w_ctrl),
    .o_next_state (w_nextState)
  );

  // State register; reset drops straight to INIT, abandoning any access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= STATE_W'(S_INIT);
    else       r_state <= w_nextState;
  end

  assign pc_write      = w_ctrl.pcWrite;
  assign pc_write_cond = w_ctrl.pcWriteCond;
  assign i_or_d        = w_ctrl.iOrD;
  assign mem_read      = w_ctrl.memRead;
  assign mem_write     = w_ctrl.memWrite;
  assign ir_write      = w_ctrl.irWrite;
  assign reg_dst       = w_ctrl.regDst;
  assign mem_to_reg    = w_ctrl.memToReg;
  assign reg_write     = w_ctrl.regWrite;
  assign alu_src_a     = w_ctrl.aluSrcA;
  assign alu_src_b     = w_ctrl.aluSrcB;
  assign alu_op        = w_ctrl.aluOp;
  assign alu_funct_sel = w_ctrl.aluFunctSel;
  assign pc_source     = w_ctrl.pcSource;
  assign instr_done    = w_ctrl.instrDone;
  assign illegal_op    = w_ctrl.illegalOp;
  assign state_dbg     = r_state;
`ifdef ILLEGAL_OP_TRAP_EN
  assign halted        = (r_state == STATE_W'(S_HALT));
`endif

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: each cycle's stimulus pushes
// the expected control word and state to a scoreboard queue, which is popped
// and compared once the outputs have settled after the falling edge.
module tb_multicycle_main_control;
  import multicycle_main_control_pkg::*;

  typedef struct packed {
    state_e     st;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iOrD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       aluFunctSel;
    logic [1:0] pcSource;
    logic       instrDone;
    logic       illegalOp;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, alu_funct_sel;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       instr_done, illegal_op;
  logic [3:0] state_dbg;
`ifdef ILLEGAL_OP_TRAP_EN
  logic       halted;
`endif

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;
  int   stepNo = 0;

  multicycle_main_control #(.STATE_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .alu_funct_sel (alu_funct_sel),
    .pc_source     (pc_source),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op),
`ifdef ILLEGAL_OP_TRAP_EN
    .halted        (halted),
`endif
    .state_dbg     (state_dbg)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no finish, required finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected control words for each state, written from the state table.
  function automatic exp_t eZero(input state_e s);
    exp_t e;
    e = '0;
    e.st = s;
    return e;
  endfunction

  function automatic exp_t eFetch(input logic rdy);
    exp_t e;
    e = eZero(S_FETCH);
    e.memRead = 1'b1; e.aluSrcB = 2'b01; e.irWrite = rdy; e.pcWrite = rdy;
    return e;
  endfunction

  function automatic exp_t eDecode(input logic ill);
    exp_t e;
    e = eZero(S_DECODE);
    e.aluSrcB = 2'b11; e.illegalOp = ill;
    return e;
  endfunction

  function automatic exp_t eMemAddr();
    exp_t e;
    e = eZero(S_MEM_ADDR);
    e.aluSrcA = 1'b1; e.aluSrcB = 2'b10;
    return e;
  endfunction

  function automatic exp_t eMemRead();
    exp_t e;
    e = eZero(S_MEM_READ);
    e.memRead = 1'b1; e.iOrD = 1'b1;
    return e;
  endfunction

  function automatic exp_t eMemWb();
    exp_t e;
    e = eZero(S_MEM_WB);
    e.memToReg = 1'b1; e.regWrite = 1'b1; e.instrDone = 1'b1;
    return e;
  endfunction

  function automatic exp_t eMemWrite(input logic rdy);
    exp_t e;
    e = eZero(S_MEM_WRITE);
    e.memWrite = 1'b1; e.iOrD = 1'b1; e.instrDone = rdy;
    return e;
  endfunction

  function automatic exp_t eRExec();
    exp_t e;
    e = eZero(S_R_EXEC);
    e.aluSrcA = 1'b1; e.aluSrcB = 2'b00; e.aluOp = 2'b10;
    return e;
  endfunction

  function automatic exp_t eRWb();
    exp_t e;
    e = eZero(S_R_WB);
    e.regDst = 1'b1; e.regWrite = 1'b1; e.instrDone = 1'b1;
    return e;
  endfunction

  function automatic exp_t eBranch();
    exp_t e;
    e = eZero(S_BRANCH);
    e.aluSrcA = 1'b1; e.aluOp = 2'b01; e.pcWriteCond = 1'b1;
    e.pcSource = 2'b01; e.instrDone = 1'b1;
    return e;
  endfunction

  function automatic exp_t eJump();
    exp_t e;
    e = eZero(S_JUMP);
    e.pcWrite = 1'b1; e.pcSource = 2'b10; e.instrDone = 1'b1;
    return e;
  endfunction

  function automatic exp_t eIExec(input logic logical);
    exp_t e;
    e = eZero(S_I_EXEC);
    e.aluSrcA = 1'b1; e.aluSrcB = 2'b10;
    e.aluOp = logical ? 2'b11 : 2'b00; e.aluFunctSel = logical;
    return e;
  endfunction

  function automatic exp_t eIWb();
    exp_t e;
    e = eZero(S_I_WB);
    e.regDst = 1'b0; e.regWrite = 1'b1; e.instrDone = 1'b1;
    return e;
  endfunction

  // Gathers the DUT outputs into the same layout as the expectations.
  function automatic exp_t observe();
    exp_t o;
    o.st = state_e'(state_dbg);
    o.pcWrite = pc_write;       o.pcWriteCond = pc_write_cond;
    o.iOrD = i_or_d;            o.memRead = mem_read;
    o.memWrite = mem_write;     o.irWrite = ir_write;
    o.regDst = reg_dst;         o.memToReg = mem_to_reg;
    o.regWrite = reg_write;     o.aluSrcA = alu_src_a;
    o.aluSrcB = alu_src_b;      o.aluOp = alu_op;
    o.aluFunctSel = alu_funct_sel; o.pcSource = pc_source;
    o.instrDone = instr_done;   o.illegalOp = illegal_op;
    return o;
  endfunction

  // Pops the oldest expectation and compares it with the settled outputs.
  task automatic checkOutput();
    exp_t e;
    exp_t o;
    if (sbQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty step%0d: observed 0 entries, required 1", stepNo);
      return;
    end
    e = sbQ.pop_front();
    o = observe();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("[TB] FAIL step%0d_%s: observed state=%0d ctrl=%h, required state=%0d ctrl=%h",
             stepNo, e.st.name(), o.st, o[20:0], e.st, e[20:0]);
    end
    stepNo++;
  endtask

  // One clock of stimulus: drive after the falling edge, queue the
  // expectation, then check once combinational outputs have settled.
  task automatic applyStimulus(input logic [5:0] op, input logic rdy,
                               input logic rst, input exp_t e);
    @(negedge clk);
    opcode    = op;
    mem_ready = rdy;
    reset     = rst;
    sbQ.push_back(e);
    #1;
    checkOutput();
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b1;
    opcode    = OP_RTYPE;

    // Reset held for three cycles, then released while still in INIT.
    for (int i = 0; i < 3; i++) applyStimulus(OP_RTYPE, 1'b1, 1'b1, eZero(S_INIT));
    applyStimulus(OP_RTYPE, 1'b1, 1'b0, eZero(S_INIT));

    // lw with two wait cycles in MEM_READ.
    applyStimulus(OP_LW, 1'b1, 1'b0, eFetch(1'b1));
    applyStimulus(OP_LW, 1'b0, 1'b0, eDecode(1'b0));
    applyStimulus(OP_LW, 1'b1, 1'b0, eMemAddr());
    applyStimulus(OP_LW, 1'b0, 1'b0, eMemRead());
    applyStimulus(OP_LW, 1'b0, 1'b0, eMemRead());
    applyStimulus(OP_LW, 1'b1, 1'b0, eMemRead());
    applyStimulus(OP_LW, 1'b0, 1'b0, eMemWb());

    // R-type, beq and j back to back.
    applyStimulus(OP_RTYPE, 1'b1, 1'b0, eFetch(1'b1));
    applyStimulus(OP_RTYPE, 1'b1, 1'b0, eDecode(1'b0));
    applyStimulus(OP_RTYPE, 1'b0, 1'b0, eRExec());
    applyStimulus(OP_RTYPE, 1'b1, 1'b0, eRWb());
    applyStimulus(OP_BEQ, 1'b1, 1'b0, eFetch(1'b1));
    applyStimulus(OP_BEQ, 1'b1, 1'b0, eDecode(1'b0));
    applyStimulus(OP_BEQ, 1'b0, 1'b0, eBranch());
    applyStimulus(OP_J, 1'b1, 1'b0, eFetch(1'b1));
    applyStimulus(OP_J, 1'b1, 1'b0, eDecode(1'b0));
    applyStimulus(OP_J, 1'b0, 1'b0, eJump());

    // Immediate forms: ori, addi, andi.
    applyStimulus(OP_ORI, 1'b1, 1'b0, eFetch(1'b1));
    applyStimulus(OP_ORI, 1'b1, 1'b0, eDecode(1'b0));
    applyStimulus(OP_ORI, 1'b1, 1'b0, eIExec(1'b1));
    applyStimulus(OP_ORI, 1'b1, 1'b0, eIWb());
    applyStimulus(OP_ADDI, 1'b1, 1'b0, eFetch(1'b1));
    applyStimulus(OP_ADDI, 1'b1, 1'b0, eDecode(1'b0));
    applyStimulus(OP_ADDI, 1'b0, 1'b0, eIExec(1'b0));
    applyStimulus(OP_ADDI, 1'b0, 1'b0, eIWb());
    applyStimulus(OP_ANDI, 1'b1, 1'b0, eFetch(1'b1));
    applyStimulus(OP_ANDI, 1'b1, 1'b0, eDecode(1'b0));
    applyStimulus(OP_ANDI, 1'b1, 1'b0, eIExec(1'b1));
    applyStimulus(OP_ANDI, 1'b1, 1'b0, eIWb());

    // sw with a fetch wait, then reset in the second store wait cycle.
    applyStimulus(OP_SW, 1'b0, 1'b0, eFetch(1'b0));
    applyStimulus(OP_SW, 1'b1, 1'b0, eFetch(1'b1));
    applyStimulus(OP_SW, 1'b1, 1'b0, eDecode(1'b0));
    applyStimulus(OP_SW, 1'b1, 1'b0, eMemAddr());
    applyStimulus(OP_SW, 1'b0, 1'b0, eMemWrite(1'b0));
    applyStimulus(OP_SW, 1'b0, 1'b0, eMemWrite(1'b0));
    #1;
    reset = 1'b1;
    sbQ.push_back(eZero(S_INIT));
    #1;
    checkOutput();
    applyStimulus(OP_SW, 1'b0, 1'b1, eZero(S_INIT));
    applyStimulus(OP_SW, 1'b0, 1'b0, eZero(S_INIT));
    applyStimulus(OP_SW, 1'b1, 1'b0, eFetch(1'b1));

    // Completed store: sw with zero wait states finishes in MEM_WRITE.
    applyStimulus(OP_SW, 1'b1, 1'b0, eDecode(1'b0));
    applyStimulus(OP_SW, 1'b1, 1'b0, eMemAddr());
    applyStimulus(OP_SW, 1'b1, 1'b0, eMemWrite(1'b1));

    // Unsupported opcode 111111.
    applyStimulus(6'b111111, 1'b1, 1'b0, eFetch(1'b1));
    applyStimulus(6'b111111, 1'b1, 1'b0, eDecode(1'b1));
`ifdef ILLEGAL_OP_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      applyStimulus(6'b111111, 1'b1, 1'b0, eZero(S_HALT));
      checks++;
      assert (halted === 1'b1) else begin
        errors++;
        $error("[TB] FAIL halted_flag: observed %b, required 1", halted);
      end
    end
    applyStimulus(OP_LW, 1'b1, 1'b1, eZero(S_INIT));
    checks++;
    assert (halted === 1'b0) else begin
      errors++;
      $error("[TB] FAIL halted_after_reset: observed %b, required 0", halted);
    end
    applyStimulus(OP_LW, 1'b1, 1'b0, eZero(S_INIT));
    applyStimulus(OP_LW, 1'b1, 1'b0, eFetch(1'b1));
`else
    applyStimulus(OP_J, 1'b1, 1'b0, eFetch(1'b1));
    applyStimulus(OP_J, 1'b1, 1'b0, eDecode(1'b0));
    applyStimulus(OP_J, 1'b1, 1'b0, eJump());
`endif

    checks++;
    assert (sbQ.size() == 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_drain: observed %0d entries, required 0", sbQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multi-cycle MIPS-subset datapath. Sits directly upstream of the ALU control unit.
- Decodes the 6-bit opcode held in the instruction register. Sequences fetch/decode/execute/memory/writeback states.
- Drives every datapath enable, the 2-bit ALUop, and the select that routes funct or opcode into the ALU control unit's function input.
- Memory accesses use a ready handshake.

Parameters:
- STATE_W, 4, width of the state register and of state_dbg; minimum 4.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- opcode  in  6  IR[31:26]; stable from the cycle after the FETCH ir_write
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- i_or_d  out  1  0=PC address, 1=ALUOut address
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  0=ALUOut, 1=MDR
- reg_write  out  1  register-file write
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=imm<<2
- alu_op  out  2  00=add (lw/sw/addi/PC), 01=subtract (beq), 10=use funct, 11=immediate logical
- alu_funct_sel  out  1  0=funct into ALU control, 1=opcode into ALU control
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- illegal_op  out  1  one-cycle pulse on unsupported opcode in DECODE
- state_dbg  out  STATE_W  current state encoding

Behaviour:
- Supported opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000, andi=001100, ori=001101.
- Outputs are Moore decodes of the state register, except the mem_ready gating noted below. Unlisted outputs are 0 in each state.
- Reset: asynchronous, forces INIT. In INIT all outputs are 0 and state_dbg=0. INIT always goes to FETCH on the next edge.
- FETCH:
  - mem_read=1, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write are asserted only while mem_ready=1.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - alu_src_b=11, alu_op=00 (branch target to ALUOut).
  - Next state: lw/sw->MEM_ADDR, R->R_EXEC, beq->BRANCH, j->JUMP, addi/andi/ori->I_EXEC.
  - Any other opcode: illegal_op=1 and next state FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, i_or_d=1. Holds until mem_ready=1, then MEM_WB.
- MEM_WB: mem_to_reg=1, reg_write=1, instr_done=1. Next FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Holds until mem_ready; instr_done=1 in the mem_ready cycle; then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next R_WB.
- R_WB: reg_dst=1, reg_write=1, instr_done=1. Next FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Next FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Next FETCH.
- I_EXEC:
  - alu_src_a=1, alu_src_b=10.
  - addi: alu_op=00, alu_funct_sel=0.
  - andi/ori: alu_op=11, alu_funct_sel=1.
  - Next I_WB.
- I_WB: reg_dst=0, reg_write=1, instr_done=1. Next FETCH.
- Memory handshake: mem_read/mem_write are held steady for every wait cycle. mem_ready outside FETCH/MEM_READ/MEM_WRITE is ignored.
- Cycle counts with zero wait states: lw 5, sw 4, R 4, addi/andi/ori 4, beq 3, j 3.
- Reset mid-instruction: returns to INIT immediately, dropping any pending access.
- Unreachable state encodings decode all outputs to 0 and go to INIT.

Optional Feature:
- Macro ILLEGAL_OP_TRAP_EN.
- Defined:
  - An illegal opcode in DECODE goes to HALT instead of FETCH.
  - HALT drives all enables 0 and is left only by reset.
  - Adds output port halted (1 bit), equal to 1 exactly in HALT.
  - The illegal_op pulse is unchanged.
- Undefined: no HALT state and no halted port; illegal opcodes resume at FETCH.

Decomposition:
- Shared package: opcode localparams, state enumeration, and alu_op / alu_src_b / pc_source encodings. The ALU control unit and the datapath mux code reuse the same encodings.
- One natural sub-module, main_control_decode: a purely combinational state+opcode+mem_ready to outputs/next-state function, instantiated by the FSM wrapper that owns the state register.

Test Plan:
- Reset held 3 cycles, released with mem_ready=1 -> all outputs 0 during reset; FETCH (state after INIT) on the first post-release edge; ir_write=pc_write=1 in FETCH.
- lw (100011), mem_ready=0 for 2 cycles in MEM_READ -> MEM_READ lasts 3 cycles with mem_read=1 and i_or_d=1 steady; MEM_WB has reg_write=1 and mem_to_reg=1; instr_done pulses once.
- R-type then beq then j back-to-back, mem_ready=1 -> alu_op sequence 00,00,10 / 00,00,01 / 00,00; beq cycle pc_write_cond=1, pc_source=01; j cycle pc_write=1, pc_source=10.
- ori (001101) -> I_EXEC alu_op=11, alu_funct_sel=1, alu_src_b=10. addi (001000) -> alu_op=00, alu_funct_sel=0. I_WB reg_write=1, reg_dst=0.
- opcode 111111 in DECODE -> illegal_op=1 for one cycle and next state FETCH. With ILLEGAL_OP_TRAP_EN: halted=1 and all enables stay 0 until reset.
- reset asserted in the second MEM_WRITE wait cycle -> mem_write drops to 0 asynchronously (same cycle); after release, FETCH follows INIT.
